// File: rtl/scan_chain_sequencer.sv
// scan_chain_sequencer
//
// Drives a daisy chain of NUM_DESIGNS scan wrappers, each IO_WIDTH bits wide.
// One transaction shifts a word into design k, latches it into the design
// inputs, captures every design's outputs into the chain and shifts the chain
// back out until design k's word has been collected.
//
// Chain geometry: bit b of design k sits at position k*IO_WIDTH+b. Data enters
// at position 0 (scan_data_out) and leaves at position NUM_DESIGNS*IO_WIDTH-1
// (scan_data_in). Words travel MSB first in both directions.
//
// Each bit period is two clk cycles: phase 0 holds scan_clk_out low, updates
// scan_data_out and samples scan_data_in; phase 1 raises scan_clk_out.
//
// Optional build macro SCAN_SEQ_SLOW_CLK_EN: slow_clk toggles once per
// completed transaction and its pre-toggle value replaces inputs[0] in the
// shifted word, giving every design one clock edge per two transactions.
// Without the macro slow_clk is tied low and inputs[0] passes unmodified.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start; out-of-range select pulses sel_err
// SHIFT_IN  | (k+1)*W bit periods: word MSB first, then zero fill
// LATCH     | 2 cycles, scan_latch_en high in the first
// CAPTURE   | 1 bit period with scan_select high (one scan_clk rising edge)
// SHIFT_OUT | (N-k)*W bit periods collecting the chain tail into a W-bit reg
// DONE      | 1 cycle: outputs loaded, ready pulses

module scan_chain_sequencer #(
    parameter int NUM_DESIGNS = 20,
    parameter int IO_WIDTH    = 8,
    parameter int SEL_WIDTH   = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_WIDTH-1:0] active_select,
    input  logic [IO_WIDTH-1:0]  inputs,
    output logic [IO_WIDTH-1:0]  outputs,
    output logic                 busy,
    output logic                 ready,
    output logic                 sel_err,
    output logic                 scan_clk_out,
    output logic                 scan_data_out,
    output logic                 scan_select,
    output logic                 scan_latch_en,
    input  logic                 scan_data_in,
    output logic                 slow_clk
);

    localparam int CHAIN_LEN = NUM_DESIGNS * IO_WIDTH;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_WIDTH:0]   NUM_SEL  = NUM_DESIGNS[SEL_WIDTH:0];
    localparam logic [IO_WIDTH-1:0]  LSB_MASK = IO_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        LATCH     = 3'd2,
        CAPTURE   = 3'd3,
        SHIFT_OUT = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  phase;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [IO_WIDTH-1:0]   in_sreg;
    logic [IO_WIDTH-1:0]   out_sreg;
    logic [IO_WIDTH-1:0]   in_word;
    logic                  sel_in_range;
    logic                  start_ok;
    logic                  last_period;

    assign sel_in_range = ({1'b0, active_select} < NUM_SEL);
    assign start_ok     = start && (state == IDLE) && sel_in_range;

    // The bit counter holds the number of bit periods still to run in the
    // current shift state; the period that sees 1 is the final one.
    assign last_period  = phase && (bit_cnt == CNT_ONE);

    // Only the shift-in state drives the chain; zero everywhere else.
    assign scan_data_out = (state == SHIFT_IN) ? in_sreg[IO_WIDTH-1] : 1'b0;

`ifdef SCAN_SEQ_SLOW_CLK_EN
    logic slow_clk_q;

    // The design clock rides in the LSB of the word, using the value before
    // this transaction's toggle.
    assign in_word  = (inputs & ~LSB_MASK) | IO_WIDTH'(slow_clk_q);
    assign slow_clk = slow_clk_q;

    // Toggle the design clock once per completed transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            slow_clk_q <= 1'b0;
        end else if (state == DONE) begin
            slow_clk_q <= ~slow_clk_q;
        end
    end
`else
    // LSB_MASK only matters when the design clock replaces inputs[0].
    logic unused_mask;
    assign unused_mask = ^LSB_MASK;
    assign in_word     = inputs;
    assign slow_clk    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and scan pin decode from the current state and bit phase.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        ready         = 1'b0;
        scan_clk_out  = 1'b0;
        scan_select   = 1'b0;
        scan_latch_en = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) begin
                    state_nxt = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                scan_clk_out = phase;
                if (last_period) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                scan_latch_en = ~phase;
                if (phase) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                scan_clk_out = phase;
                scan_select  = 1'b1;
                if (phase) begin
                    state_nxt = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                scan_clk_out = phase;
                if (last_period) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: bit phase, period down-counter, shift registers, result and
    // the select-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= 1'b0;
            bit_cnt  <= '0;
            sel_q    <= '0;
            in_sreg  <= '0;
            out_sreg <= '0;
            outputs  <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_err <= start && (state == IDLE) && !sel_in_range;

            // Every timed state lasts a whole number of bit periods, so the
            // phase naturally lands on 0 at each state entry.
            if ((state == IDLE) || (state == DONE)) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
            end

            if (start_ok) begin
                sel_q   <= active_select;
                in_sreg <= in_word;
                bit_cnt <= CNT_W'((int'(active_select) + 1) * IO_WIDTH);
            end

            if ((state == SHIFT_IN) && phase) begin
                in_sreg <= in_sreg << 1;
                bit_cnt <= bit_cnt - CNT_ONE;
            end

            // The tail must travel past designs k+1..N-1 before design k's
            // word arrives, hence (N-k)*W periods.
            if ((state == CAPTURE) && phase) begin
                bit_cnt <= CNT_W'((NUM_DESIGNS - int'(sel_q)) * IO_WIDTH);
            end

            if (state == SHIFT_OUT) begin
                if (!phase) begin
                    out_sreg <= (out_sreg << 1) | IO_WIDTH'(scan_data_in);
                end else begin
                    bit_cnt <= bit_cnt - CNT_ONE;
                end
            end

            if (state == DONE) begin
                outputs <= out_sreg;
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Bench for scan_chain_sequencer with a 4-design, 8-bit chain. The chain and
// designs are modelled behaviourally (each design outputs its latched input
// plus one). A timeline model derives every scan pin from the cycle offset
// since start acceptance and is compared against the DUT on every negedge.
module tb_scan_chain_sequencer;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int SW  = 9;
    localparam int LAT = 2 * W * (N + 1) + 5;

    logic          clk = 1'b0;
    logic          rst_drv = 1'b1;
    logic          start_drv = 1'b0;
    logic [SW-1:0] sel_drv = '0;
    logic [W-1:0]  in_drv = '0;

    logic [W-1:0]  outputs;
    logic          busy, ready, sel_err;
    logic          scan_clk_out, scan_data_out, scan_select, scan_latch_en;
    logic          scan_data_in;
    logic          slow_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    scan_chain_sequencer #(
        .NUM_DESIGNS (N),
        .IO_WIDTH    (W),
        .SEL_WIDTH   (SW)
    ) dut (
        .clk           (clk),
        .reset         (rst_drv),
        .start         (start_drv),
        .active_select (sel_drv),
        .inputs        (in_drv),
        .outputs       (outputs),
        .busy          (busy),
        .ready         (ready),
        .sel_err       (sel_err),
        .scan_clk_out  (scan_clk_out),
        .scan_data_out (scan_data_out),
        .scan_select   (scan_select),
        .scan_latch_en (scan_latch_en),
        .scan_data_in  (scan_data_in),
        .slow_clk      (slow_clk)
    );

    always #5 clk = ~clk;

    // ---------------- chain and user designs ----------------
    logic [N*W-1:0] chain = '0;
    logic [W-1:0]   latched [N];
    int             scan_edges = 0;

    assign scan_data_in = chain[N*W-1];

    always @(posedge scan_clk_out) begin
        scan_edges++;
        if (scan_select) begin
            for (int k = 0; k < N; k++) chain[k*W +: W] = latched[k] + 8'd1;
        end else begin
            chain = {chain[N*W-2:0], scan_data_out};
        end
    end

    always @(negedge clk) begin
        if (rst_drv) begin
            for (int k = 0; k < N; k++) latched[k] = '0;
        end else if (scan_latch_en) begin
            for (int k = 0; k < N; k++) latched[k] = chain[k*W +: W];
        end
    end

    // ---------------- transaction timeline model ----------------
    int         m_c = 0;      // cycle offset since acceptance, 0 = idle
    int         m_k = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_resp = '0;
    logic [W-1:0] m_out = '0;
    logic       m_slow = 1'b0;
    logic       m_selerr = 1'b0;

    always @(posedge clk) begin
        if (rst_drv) begin
            m_c = 0; m_out = '0; m_slow = 1'b0; m_selerr = 1'b0;
        end else begin
            m_selerr = 1'b0;
            if (m_c != 0) begin
                if (m_c == LAT) begin
                    m_c   = 0;
                    m_out = m_resp;
`ifdef SCAN_SEQ_SLOW_CLK_EN
                    m_slow = ~m_slow;
`endif
                end else begin
                    m_c = m_c + 1;
                end
            end else if (start_drv) begin
                if (int'(sel_drv) < N) begin
                    m_c = 1;
                    m_k = int'(sel_drv);
`ifdef SCAN_SEQ_SLOW_CLK_EN
                    m_word = {in_drv[W-1:1], m_slow};
`else
                    m_word = in_drv;
`endif
                    m_resp = m_word + 8'd1;
                end else begin
                    m_selerr = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the timeline model.
    always @(negedge clk) begin : cmp
        int   si;
        int   p;
        logic e_clk, e_sdo, e_sel, e_lat;
        if (check_en) begin
            e_clk = 1'b0; e_sdo = 1'b0; e_sel = 1'b0; e_lat = 1'b0;
            si = 2 * (m_k + 1) * W;
            if (m_c >= 1 && m_c <= si) begin
                p     = (m_c - 1) / 2;
                e_clk = ((m_c - 1) % 2) == 1;
                if (p < W) e_sdo = m_word[W-1-p];
            end else if (m_c == si + 1) begin
                e_lat = 1'b1;
            end else if (m_c == si + 3) begin
                e_sel = 1'b1;
            end else if (m_c == si + 4) begin
                e_sel = 1'b1;
                e_clk = 1'b1;
            end else if (m_c >= si + 5 && m_c < LAT) begin
                e_clk = ((m_c - si - 5) % 2) == 1;
            end
            check("busy", busy, m_c != 0);
            check("ready", ready, m_c == LAT);
            check("sel_err", sel_err, m_selerr);
            check("scan_clk_out", scan_clk_out, e_clk);
            check("scan_data_out", scan_data_out, e_sdo);
            check("scan_select", scan_select, e_sel);
            check("scan_latch_en", scan_latch_en, e_lat);
            check("outputs", outputs, m_out);
            check("slow_clk", slow_clk, m_slow);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input int k, input logic [W-1:0] word, output int lat, output int edges);
        int e0;
        @(negedge clk);
        start_drv = 1'b1; sel_drv = SW'(k); in_drv = word;
        e0 = scan_edges;
        @(negedge clk);
        start_drv = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        edges = scan_edges - e0;
        @(negedge clk);
    endtask

    task automatic do_reject(input int k);
        int e0;
        @(negedge clk);
        start_drv = 1'b1; sel_drv = SW'(k); in_drv = 8'h11;
        e0 = scan_edges;
        @(negedge clk);
        start_drv = 1'b0;
        check("rej_sel_err_pulse", sel_err, 1);
        check("rej_busy", busy, 0);
        @(negedge clk);
        check("rej_sel_err_end", sel_err, 0);
        check("rej_busy2", busy, 0);
        check("rej_edges", scan_edges - e0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_drv = 1'b1; start_drv = 1'b0;
        repeat (3) @(negedge clk);
        rst_drv = 1'b0;
    endtask

    initial begin
        int lat, edges, rdy_cnt, k;
        logic [W-1:0] word, exp3;
        logic [3:0] exp_slow_seq, exp_bit_seq;

        repeat (3) @(negedge clk);
        rst_drv  = 1'b0;
        check_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_outputs", outputs, 0);
        check("rst_scan_clk", scan_clk_out, 0);
        check("rst_latch_en", scan_latch_en, 0);
        check("rst_slow_clk", slow_clk, 0);

        // k=2, 0x5A
        do_txn(2, 8'h5A, lat, edges);
        check("t1_latency", lat, 85);
        check("t1_edges", edges, 41);
        check("t1_outputs", outputs, 8'h5B);
        check("t1_d2", latched[2], 8'h5A);
        check("t1_d0", latched[0], 8'h00);
        check("t1_d1", latched[1], 8'h00);
        check("t1_d3", latched[3], 8'h00);

        // chain ends, all ones
        do_txn(0, 8'hFF, lat, edges);
        check("t2_outputs", outputs, 8'h00);
        check("t2_edges", edges, 8 + 1 + 32);
`ifdef SCAN_SEQ_SLOW_CLK_EN
        exp3 = 8'hFF;
`else
        exp3 = 8'h00;
`endif
        do_txn(3, 8'hFF, lat, edges);
        check("t3_outputs", outputs, exp3);
        check("t3_edges", edges, 32 + 1 + 8);

        do_reject(4);

        // second start mid shift-in is ignored
        @(negedge clk);
        start_drv = 1'b1; sel_drv = SW'(1); in_drv = 8'h33;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (10) @(negedge clk);
        start_drv = 1'b1; sel_drv = SW'(3); in_drv = 8'hC0;
        @(negedge clk);
        start_drv = 1'b0;
        check("t5_no_err", sel_err, 0);
        rdy_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (ready === 1'b1) rdy_cnt++;
        end
        check("t5_ready_count", rdy_cnt, 1);
        check("t5_outputs", outputs, 8'h34);

        // reset during shift-out
        @(negedge clk);
        start_drv = 1'b1; sel_drv = SW'(1); in_drv = 8'h40;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (50) @(negedge clk);
        check("t6_busy_before", busy, 1);
        rst_drv = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_outputs", outputs, 0);
        check("t6_scan_clk", scan_clk_out, 0);
        rst_drv = 1'b0;
        do_txn(2, 8'h7E, lat, edges);
        check("t6_latency", lat, 85);
        check("t6_after_outputs", outputs, 8'h7F);

        // randomized transactions
        for (int i = 0; i < 16; i++) begin
            k    = int'($urandom_range(0, 5));
            word = W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (k < N) begin
                do_txn(k, word, lat, edges);
                check("rnd_latency", lat, LAT);
                check("rnd_edges", edges, (N + 1) * W + 1);
                check("rnd_latched", latched[k], m_word);
                check("rnd_outputs", outputs, m_word + 8'd1);
            end else begin
                do_reject(k);
            end
        end

        // design clock sequence over four back-to-back transactions on k=1
        apply_reset();
`ifdef SCAN_SEQ_SLOW_CLK_EN
        exp_slow_seq = 4'b0101;
        exp_bit_seq  = 4'b1010;
`else
        exp_slow_seq = 4'b0000;
        exp_bit_seq  = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 8'hA5, lat, edges);
            check("slow_clk_seq", slow_clk, exp_slow_seq[i]);
            check("slow_bit_seq", latched[1][0], exp_bit_seq[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_chain_sequencer.md
Name: scan_chain_sequencer

Overview:
- Parametrised successor to the fixed 20-design, 8-bit scan controller.
- Drives a daisy-chained shift register of NUM_DESIGNS user designs, each IO_WIDTH bits wide: shifts an input word to the selected design, latches it, captures that design's outputs, and shifts them back.
- Sits between the caravel IO/LA pins and the first scan wrapper in the chain; the last wrapper's data returns on scan_data_in.

Parameters:
- NUM_DESIGNS, 20, designs in the chain (1..512)
- IO_WIDTH, 8, bits per design in each direction (1..32)
- SEL_WIDTH, 9, width of active_select; must satisfy 2**SEL_WIDTH >= NUM_DESIGNS

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run one transaction
- active_select  in  SEL_WIDTH  index k of the target design; sampled when start is accepted
- inputs  in  IO_WIDTH  word for design k; sampled when start is accepted
- outputs  out  IO_WIDTH  last captured word from design k
- busy  out  1  high from start acceptance through DONE
- ready  out  1  one-cycle pulse in DONE
- sel_err  out  1  one-cycle pulse when start is rejected because k >= NUM_DESIGNS
- scan_clk_out  out  1  chain shift clock
- scan_data_out  out  1  serial data into design 0
- scan_select  out  1  1 = chain captures design outputs on the next scan_clk rising edge
- scan_latch_en  out  1  transfers chain contents to the design inputs
- scan_data_in  in  1  serial data from the chain tail (position NUM_DESIGNS*IO_WIDTH-1)
- slow_clk  out  1  design clock; see Optional Feature

Behaviour:
- Reset values: all outputs 0, outputs = 0, FSM = IDLE. Reset asserted in any state returns to IDLE on the next edge, with scan_clk_out and scan_latch_en low.
- Chain geometry: bit b of design k sits at position k*IO_WIDTH+b. Words travel MSB first in both directions.
- Bit period: 2 clk cycles.
  - Phase 0: scan_clk_out=0; scan_data_out updates; scan_data_in is sampled.
  - Phase 1: scan_clk_out=1.
- Let N = NUM_DESIGNS and W = IO_WIDTH.
- States:
  - IDLE: start=1 with k<N latches k and inputs, sets busy, goes to SHIFT_IN. start=1 with k>=N pulses sel_err and stays in IDLE.
  - SHIFT_IN: (k+1)*W bit periods. The first W bits are inputs[W-1..0], MSB first; the remaining bits are 0. Goes to LATCH.
  - LATCH: 2 cycles; scan_latch_en=1 in the first cycle only. Goes to CAPTURE.
  - CAPTURE: 1 bit period with scan_select=1 (one scan_clk rising edge). scan_select drops after phase 1. Goes to SHIFT_OUT.
  - SHIFT_OUT: (N-k)*W bit periods, scan_data_out=0. Each phase-0 sample shifts into a W-bit register from the LSB. The final register value equals design k's outputs. Goes to DONE.
  - DONE: 1 cycle. outputs is loaded, ready=1, busy stays 1. Goes to IDLE.
- Latency from start acceptance to ready = 2*(k+1)*W + 2 + 2 + 2*(N-k)*W + 1 = 2*W*(N+1) + 5 cycles.
- start while busy: ignored, with no error pulse.
- Bit counter width: clog2(N*W+1). No wrap occurs within a transaction.
- outputs holds its value between transactions and changes only in DONE.

Optional Feature:
- Macro: SCAN_SEQ_SLOW_CLK_EN.
- Defined:
  - slow_clk toggles in each DONE cycle.
  - The value shifted in as inputs[0] is replaced by the pre-toggle slow_clk value, so each design sees one clock edge per two transactions.
- Undefined:
  - slow_clk is tied to 0.
  - inputs[0] is passed unmodified.

Test Plan (N=4, W=8, behavioural chain model with designs computing out = in + 1):
- reset, then start with k=2, inputs=0x5A -> ready after 2*8*5+5 = 85 cycles; outputs=0x5B; design 2 latched 0x5A; designs 0, 1, 3 latched 0x00.
- k=0 and k=3 each with inputs=0xFF -> outputs=0x00 for both; scan_clk rising edges counted = 8+1+32 (k=0) and 32+1+8 (k=3).
- start with k=4 -> sel_err pulses 1 cycle; busy stays 0; no scan_clk edges.
- second start pulse while busy mid-SHIFT_IN -> ignored; exactly one ready pulse.
- reset asserted during SHIFT_OUT -> next cycle: busy=0, outputs=0, scan_clk_out=0; a subsequent transaction completes correctly.
- SCAN_SEQ_SLOW_CLK_EN defined, 4 back-to-back transactions on k=1 -> slow_clk sequence 1,0,1,0 after each DONE; design 1 sees inputs[0] = 0,1,0,1.
